// File: rtl/spart_tx.sv
// SPART transmitter: double-buffered 8N1 serialiser clocked by the shared
// baud oversample tick; a holding register feeds the shift register.
module spart_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_en,
  input  logic       load,
  input  logic [7:0] din,
  output logic       txd,
  output logic       tbr,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tick, tick_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [7:0]    hold;
  logic          hold_full;
  logic          xfer;
  logic          accept;
  logic          txd_nxt;

  // A load is only taken while the holding register is empty; it can never
  // coincide with a transfer, which needs the register full.
  assign accept = load && !hold_full;
  assign tbr    = !hold_full;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          xfer      = 1'b1;
          shift_nxt = hold;
          tick_nxt  = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (baud_en) begin
          if (tick == TICK_LAST) begin
            tick_nxt  = '0;
            bit_nxt   = '0;
            state_nxt = DATA;
          end else begin
            tick_nxt = tick + TW'(1);
          end
        end
      end
      DATA: begin
        if (baud_en) begin
          if (tick == TICK_LAST) begin
            tick_nxt  = '0;
            shift_nxt = {1'b0, shift[7:1]};
            if (bit_cnt == BIT_LAST) begin
              state_nxt = STOP;
            end else begin
              bit_nxt = bit_cnt + BW'(1);
            end
          end else begin
            tick_nxt = tick + TW'(1);
          end
        end
      end
      STOP: begin
        if (baud_en) begin
          if (tick == TICK_LAST) begin
            tick_nxt = '0;
            if (hold_full) begin
              xfer      = 1'b1;
              shift_nxt = hold;
              state_nxt = START;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            tick_nxt = tick + TW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // txd is registered from the next state so it changes on the same edge
    // as the state and never glitches.
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift_nxt[0];
      default: txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick      <= '0;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
      txd       <= 1'b1;
    end else begin
      state   <= state_nxt;
      tick    <= tick_nxt;
      bit_cnt <= bit_nxt;
      txd     <= txd_nxt;
      if (xfer) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
      end
    end
  end

  // Data registers carry no reset; their contents are qualified by state.
  always_ff @(posedge clk) begin
    shift <= shift_nxt;
    if (accept) begin
      hold <= din;
    end
  end

endmodule
